rfphoenix_ictag_lru: RTL and testbench
======================================

RFPHOENIX_ICTAG_LRU -- requirements
Module: rfphoenix_ictag_lru

Interface
REQ-001 SHALL have parameter AWID, default 32, meaning code address width in bits.
REQ-002 SHALL have parameter LINES, default 128, meaning sets per way (power of 2); IDXW = log2(LINES).
REQ-003 SHALL have parameter WAYS, default 4, meaning associativity (power of 2, 2..8); WW = log2(WAYS).
REQ-004 SHALL have parameter LINEW, default 6, meaning log2 of line size in bytes; tag = adr[AWID-1:LINEW+IDXW], set = adr[LINEW+IDXW-1:LINEW].
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rd_en, input, 1, lookup request.
REQ-008 SHALL have port rd_adr, input, AWID, lookup address.
REQ-009 SHALL have port hit, output, 1, lookup hit (registered).
REQ-010 SHALL have port miss, output, 1, lookup miss (registered).
REQ-011 SHALL have port hit_way, output, WW, matching way on hit.
REQ-012 SHALL have port fill, input, 1, write tag for fill_adr and mark valid.
REQ-013 SHALL have port fill_adr, input, AWID, fill address.
REQ-014 SHALL have port fill_way, output, WW, way chosen by the current fill (combinational).
REQ-015 SHALL have port inv_line, input, 1, invalidate the line matching inv_adr.
REQ-016 SHALL have port inv_adr, input, AWID, invalidate address.
REQ-017 SHALL have port inv_all, input, 1, start whole-cache invalidate sweep.
REQ-018 SHALL have port busy, output, 1, invalidate sweep in progress.

Function
REQ-019 SHALL store tags in a WAYS*LINES array (block RAM, never reset) plus one valid bit and per-set round-robin pointer rr[set] (WW bits).
REQ-020 SHALL, for rd_en=1 at cycle N with busy=0, drive in cycle N+1 hit=1 if any way of the set is valid with equal tag, else miss=1; hit_way = lowest matching way, 0 on miss.
REQ-021 SHALL drive hit=0, miss=0, hit_way=0 in cycle N+1 when rd_en=0 or busy=1 at cycle N.
REQ-022 SHALL choose fill_way as the lowest-numbered invalid way of the fill set, else rr[set].
REQ-023 SHALL, on fill with busy=0, write tag and set valid in fill_way; rr[set] increments modulo WAYS only when no invalid way existed.
REQ-024 SHALL, on inv_line with busy=0, clear valid of every way in the inv_adr set whose tag equals inv_adr's tag; rr unchanged; no match is a no-op.
REQ-025 SHALL implement FSM IDLE/SWEEP: inv_all in IDLE -> SWEEP with counter=0; SWEEP clears all ways' valid and rr for set=counter each cycle; after set LINES-1 -> IDLE; busy=1 exactly in SWEEP (LINES cycles).
REQ-026 SHALL ignore inv_all, fill and inv_line while busy=1.
REQ-027 SHALL apply priority inv_all > inv_line > fill in the same cycle; lower-priority request dropped.
REQ-028 SHALL give lookups read-before-write: lookup in the same cycle as fill/inv_line to the same set sees prior state.

Reset
REQ-029 SHALL, while rst=1, force state SWEEP with counter=0, hit=0, miss=0, hit_way=0, busy=1; sweep runs LINES cycles after rst falls; rst mid-sweep restarts at counter=0.
REQ-030 SHALL leave tag contents undefined across reset; only valid bits and rr are cleared.

Verification (WAYS=4, LINES=128, LINEW=6, AWID=32)
REQ-031 rst 1 cycle -> busy=1 for 128 cycles after rst falls; then rd 0x00002040 -> miss=1, hit=0 next cycle.
REQ-032 fill 0x00002040 -> fill_way=0; rd 0x0000207C next cycle -> hit=1, hit_way=0 following cycle.
REQ-033 fills 0x2040,0x4040,0x6040,0x8040,0xA040 (set 1) -> fill_way 0,1,2,3,0; rd 0x2040 -> miss; rd 0xA040 -> hit way 0; next full-set fill uses way 1.
REQ-034 after REQ-033, inv_line 0x4040 -> rd 0x4040 miss, rd 0x6040 hit way 2; next fill to set 1 -> fill_way=1, rr unchanged.
REQ-035 inv_all with simultaneous inv_line/fill -> only sweep runs; during busy rd gives hit=0 miss=0, fill ignored; after 128 cycles every earlier-filled address misses.
REQ-036 rd 0x00002040 and fill 0x00002040 same cycle -> miss=1; rd repeated next cycle -> hit=1, hit_way=0.

Source files
------------

// File: rtl/rfphoenix_ictag_lru.sv
// Instruction-cache tag store: WAYS-way set-associative lookup, fill with
// invalid-first / round-robin victim choice, per-line and whole-cache invalidate.
module rfphoenix_ictag_lru #(
  parameter int AWID  = 32,
  parameter int LINES = 128,
  parameter int WAYS  = 4,
  parameter int LINEW = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [AWID-1:0]          rd_adr,
  output logic                     hit,
  output logic                     miss,
  output logic [$clog2(WAYS)-1:0]  hit_way,
  input  logic                     fill,
  input  logic [AWID-1:0]          fill_adr,
  output logic [$clog2(WAYS)-1:0]  fill_way,
  input  logic                     inv_line,
  input  logic [AWID-1:0]          inv_adr,
  input  logic                     inv_all,
  output logic                     busy
);

  localparam int IDXW = $clog2(LINES);
  localparam int WW   = $clog2(WAYS);
  localparam int TAGW = AWID - LINEW - IDXW;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  logic [IDXW-1:0] sweep_cnt;

  // Tag RAM is never reset; the valid bits alone decide what is live.
  logic [TAGW-1:0] tag_mem [WAYS][LINES];
  logic [WAYS-1:0] valid   [LINES];
  logic [WW-1:0]   rr      [LINES];

  logic [TAGW-1:0] rd_tag, fill_tag, inv_tag;
  logic [IDXW-1:0] rd_set, fill_set, inv_set;

  assign rd_tag   = rd_adr[AWID-1:LINEW+IDXW];
  assign fill_tag = fill_adr[AWID-1:LINEW+IDXW];
  assign inv_tag  = inv_adr[AWID-1:LINEW+IDXW];
  assign rd_set   = rd_adr[LINEW+IDXW-1:LINEW];
  assign fill_set = fill_adr[LINEW+IDXW-1:LINEW];
  assign inv_set  = inv_adr[LINEW+IDXW-1:LINEW];

  logic unused_offset_bits;
  assign unused_offset_bits = ^{rd_adr[LINEW-1:0], fill_adr[LINEW-1:0], inv_adr[LINEW-1:0]};

  logic [WAYS-1:0] rd_match, inv_match, fill_free;
  logic [WW-1:0]   rd_way, free_way;

  always_comb begin
    rd_match  = '0;
    inv_match = '0;
    fill_free = '0;
    rd_way    = '0;
    free_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      rd_match[w]  = valid[rd_set][w] && (tag_mem[w][rd_set] == rd_tag);
      inv_match[w] = valid[inv_set][w] && (tag_mem[w][inv_set] == inv_tag);
      fill_free[w] = !valid[fill_set][w];
    end
    // Descending scan leaves the lowest-numbered candidate selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_match[w])  rd_way   = WW'(w);
      if (fill_free[w]) free_way = WW'(w);
    end
  end

  assign fill_way = (|fill_free) ? free_way : rr[fill_set];
  assign busy     = (state == SWEEP);

  logic do_fill;
  assign do_fill = (state == IDLE) && !rst && !inv_all && !inv_line && fill;

  always_ff @(posedge clk) begin
    if (do_fill) tag_mem[fill_way][fill_set] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      hit_way   <= '0;
    end else begin
      hit     <= 1'b0;
      miss    <= 1'b0;
      hit_way <= '0;
      case (state)
        IDLE: begin
          // Lookup uses pre-update state, so a same-cycle fill/inv is not seen.
          if (rd_en) begin
            hit     <= |rd_match;
            miss    <= ~|rd_match;
            hit_way <= rd_way;
          end
          if (inv_all) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end else if (inv_line) begin
            valid[inv_set] <= valid[inv_set] & ~inv_match;
          end else if (fill) begin
            valid[fill_set][fill_way] <= 1'b1;
            if (&valid[fill_set]) rr[fill_set] <= rr[fill_set] + WW'(1);
          end
        end
        SWEEP: begin
          valid[sweep_cnt] <= '0;
          rr[sweep_cnt]    <= '0;
          sweep_cnt        <= sweep_cnt + IDXW'(1);
          if (sweep_cnt == IDXW'(LINES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfphoenix_ictag_lru.sv
// Bench for rfphoenix_ictag_lru: directed scenarios plus random traffic
// checked against a set/way array model of the cache rules.
module tb_rfphoenix_ictag_lru;
  localparam int AWID  = 32;
  localparam int LINES = 128;
  localparam int WAYS  = 4;
  localparam int LINEW = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, fill, inv_line, inv_all;
  logic [31:0] rd_adr, fill_adr, inv_adr;
  logic        hit, miss, busy;
  logic [1:0]  hit_way, fill_way;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain arrays indexed by set and way.
  bit m_valid [LINES][WAYS];
  int m_tag   [LINES][WAYS];
  int m_rr    [LINES];
  int m_busy_left = 0;

  always #5 clk = ~clk;

  rfphoenix_ictag_lru #(.AWID(AWID), .LINES(LINES), .WAYS(WAYS), .LINEW(LINEW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_adr(rd_adr), .hit(hit), .miss(miss),
    .hit_way(hit_way), .fill(fill), .fill_adr(fill_adr), .fill_way(fill_way),
    .inv_line(inv_line), .inv_adr(inv_adr), .inv_all(inv_all), .busy(busy)
  );

  function automatic int set_of(input logic [31:0] a);
    return int'(a / 64) % LINES;
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'(a / (64 * LINES));
  endfunction

  function automatic int model_fill_way(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    return m_rr[s];
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < LINES; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  // One clock of stimulus; inputs change on the falling edge.
  task automatic apply(input bit r, input logic [31:0] ra, input bit f, input logic [31:0] fa,
                       input bit il, input logic [31:0] ia, input bit iall);
    bit         e_hit, e_miss, e_busy, any_free;
    int         e_way, e_fw, s, v;
    logic [1:0] ew;
    rd_en = r; rd_adr = ra; fill = f; fill_adr = fa;
    inv_line = il; inv_adr = ia; inv_all = iall;
    #1;
    e_hit = 1'b0; e_miss = 1'b0; e_way = 0;
    if (m_busy_left == 0) begin
      e_fw = model_fill_way(set_of(fa));
      ew = e_fw[1:0];
      n_vec++;
      if (fill_way !== ew) begin
        n_err++;
        $display("FAIL fill_way adr=%h got %0d want %0d", fa, fill_way, ew);
      end
      if (r) begin
        s = set_of(ra);
        e_miss = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--)
          if (m_valid[s][w] && m_tag[s][w] == tag_of(ra)) begin
            e_hit = 1'b1; e_miss = 1'b0; e_way = w;
          end
      end
      if (iall) begin
        model_clear();
        m_busy_left = LINES;
      end else if (il) begin
        s = set_of(ia);
        for (int w = 0; w < WAYS; w++)
          if (m_valid[s][w] && m_tag[s][w] == tag_of(ia)) m_valid[s][w] = 1'b0;
      end else if (f) begin
        s = set_of(fa);
        any_free = 1'b0;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) any_free = 1'b1;
        v = e_fw;
        if (!any_free) m_rr[s] = (m_rr[s] + 1) % WAYS;
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = tag_of(fa);
      end
    end else begin
      m_busy_left--;
    end
    e_busy = (m_busy_left > 0);
    @(posedge clk);
    @(negedge clk);
    ew = e_way[1:0];
    n_vec++;
    if (hit !== e_hit) begin
      n_err++; $display("FAIL hit adr=%h got %b want %b", ra, hit, e_hit);
    end
    n_vec++;
    if (miss !== e_miss) begin
      n_err++; $display("FAIL miss adr=%h got %b want %b", ra, miss, e_miss);
    end
    n_vec++;
    if (hit_way !== ew) begin
      n_err++; $display("FAIL hit_way adr=%h got %0d want %0d", ra, hit_way, ew);
    end
    n_vec++;
    if (busy !== e_busy) begin
      n_err++; $display("FAIL busy got %b want %b", busy, e_busy);
    end
  endtask

  task automatic idle();
    apply(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic rd(input logic [31:0] a);
    apply(1, a, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic fl(input logic [31:0] a);
    apply(0, 32'h0, 1, a, 0, 32'h0, 0);
  endtask

  task automatic inv(input logic [31:0] a);
    apply(0, 32'h0, 0, 32'h0, 1, a, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_busy_left > 0 && k < LINES + 10) begin
      idle();
      k++;
    end
  endtask

  // Pulse reset for one cycle and count busy cycles after it falls.
  task automatic do_reset();
    int n = 0;
    rst = 1'b1;
    rd_en = 0; fill = 0; inv_line = 0; inv_all = 0;
    rd_adr = '0; fill_adr = '0; inv_adr = '0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || hit !== 1'b0 || miss !== 1'b0 || hit_way !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs busy=%b hit=%b miss=%b hit_way=%0d want 1 0 0 0", busy, hit, miss, hit_way);
    end
    rst = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n != LINES) begin
      n_err++; $display("FAIL reset_busy_len got %0d want %0d", n, LINES);
    end
    model_clear();
    m_busy_left = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rd(32'h0000_2040);
  endtask

  task automatic test_fill_hit();
    fl(32'h0000_2040);
    rd(32'h0000_207C);
  endtask

  task automatic test_round_robin();
    apply(0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    wait_idle();
    fl(32'h0000_2040);
    fl(32'h0000_4040);
    fl(32'h0000_6040);
    fl(32'h0000_8040);
    fl(32'h0000_A040);
    rd(32'h0000_2040);
    rd(32'h0000_A040);
  endtask

  task automatic test_inv_line();
    inv(32'h0000_4040);
    rd(32'h0000_4040);
    rd(32'h0000_6040);
    inv(32'h0001_2040);
    fl(32'h0000_C040);
    fl(32'h0000_E040);
    rd(32'h0000_C040);
    rd(32'h0000_E040);
    rd(32'h0000_6040);
  endtask

  task automatic test_inv_all();
    apply(0, 32'h0, 1, 32'h0001_0040, 1, 32'h0000_A040, 1);
    rd(32'h0000_6040);
    apply(1, 32'h0000_A040, 1, 32'h0000_2040, 0, 32'h0, 0);
    fl(32'h0000_4040);
    wait_idle();
    rd(32'h0000_2040);
    rd(32'h0000_4040);
    rd(32'h0000_6040);
    rd(32'h0000_A040);
    rd(32'h0000_C040);
    rd(32'h0000_E040);
    rd(32'h0001_0040);
  endtask

  task automatic test_read_before_write();
    apply(1, 32'h0000_2040, 1, 32'h0000_2040, 0, 32'h0, 0);
    rd(32'h0000_2040);
    apply(1, 32'h0000_2040, 0, 32'h0, 1, 32'h0000_2040, 0);
    rd(32'h0000_2040);
  endtask

  task automatic test_reset_mid_sweep();
    fl(32'h0000_3080);
    apply(0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    for (int i = 0; i < 30; i++) idle();
    do_reset();
    rd(32'h0000_3080);
  endtask

  task automatic test_random();
    logic [31:0] a [3];
    bit r, f, il, iall;
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < 3; j++)
        a[j] = ($urandom_range(0, 5) << 13) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      r    = ($urandom_range(0, 99) < 60);
      f    = ($urandom_range(0, 99) < 35);
      il   = ($urandom_range(0, 99) < 12);
      iall = ($urandom_range(0, 299) == 0);
      apply(r, a[0], f, a[1], il, a[2], iall);
    end
    wait_idle();
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 0; fill = 0; inv_line = 0; inv_all = 0;
    rd_adr = '0; fill_adr = '0; inv_adr = '0;
    test_reset();
    test_fill_hit();
    test_round_robin();
    test_inv_line();
    test_inv_all();
    test_read_before_write();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
